// File: rtl/boom_line_buffer_if.sv
// boom_line_buffer_if: write-beat, read-request, read-response and clear channels
// of the line buffer, plus the per-slot line-full status vector.
interface boom_line_buffer_if #(
  parameter int DATA_W = 128,
  parameter int N_IDS  = 4
);
  logic              io_wreq_valid;
  logic              io_wreq_ready;
  logic [1:0]        io_wreq_bits_id;
  logic [1:0]        io_wreq_bits_offset;
  logic [DATA_W-1:0] io_wreq_bits_data;
  logic              io_rreq_valid;
  logic              io_rreq_ready;
  logic [1:0]        io_rreq_bits_id;
  logic [1:0]        io_rreq_bits_offset;
  logic              io_rresp_valid;
  logic              io_rresp_ready;
  logic [DATA_W-1:0] io_rresp_bits_data;
  logic              io_clear_valid;
  logic [1:0]        io_clear_id;
  logic [N_IDS-1:0]  io_line_full;

  modport master (
    output io_wreq_valid, io_wreq_bits_id, io_wreq_bits_offset, io_wreq_bits_data,
    output io_rreq_valid, io_rreq_bits_id, io_rreq_bits_offset,
    output io_rresp_ready, io_clear_valid, io_clear_id,
    input  io_wreq_ready, io_rreq_ready, io_rresp_valid, io_rresp_bits_data, io_line_full
  );

  modport slave (
    input  io_wreq_valid, io_wreq_bits_id, io_wreq_bits_offset, io_wreq_bits_data,
    input  io_rreq_valid, io_rreq_bits_id, io_rreq_bits_offset,
    input  io_rresp_ready, io_clear_valid, io_clear_id,
    output io_wreq_ready, io_rreq_ready, io_rresp_valid, io_rresp_bits_data, io_line_full
  );
endinterface

// File: rtl/boom_line_buffer.sv
// boom_line_buffer: N_IDS x N_BEATS beat store with per-beat valid bits and a one-entry read response register.
// Optional feature: define LB_WRITE_BYPASS_EN to let a read hit on a same-cycle write to the same beat.
module boom_line_buffer #(
  parameter int DATA_W  = 128,
  parameter int N_IDS   = 4,
  parameter int N_BEATS = 4
) (
  input logic               clock,
  input logic               reset,
  boom_line_buffer_if.slave bus_io
);
  logic [N_IDS-1:0][N_BEATS-1:0] valid_q, valid_d;
  logic [DATA_W-1:0]             data_q [N_IDS][N_BEATS];
  logic                          rresp_valid_q, rresp_valid_d;
  logic [DATA_W-1:0]             rresp_data_q, rresp_data_d;
  logic                          beat_valid_s, bypass_s, hit_s, rreq_fire_s;
  logic [DATA_W-1:0]             rd_data_s;
  logic [N_IDS-1:0]              line_full_s;

  // Read-side hit detection, accept decision and read data selection.
  always_comb begin
    beat_valid_s = valid_q[bus_io.io_rreq_bits_id][bus_io.io_rreq_bits_offset];
`ifdef LB_WRITE_BYPASS_EN
    bypass_s = bus_io.io_wreq_valid
               && (bus_io.io_wreq_bits_id == bus_io.io_rreq_bits_id)
               && (bus_io.io_wreq_bits_offset == bus_io.io_rreq_bits_offset);
    if (bypass_s) begin
      rd_data_s = bus_io.io_wreq_bits_data;
    end else begin
      rd_data_s = data_q[bus_io.io_rreq_bits_id][bus_io.io_rreq_bits_offset];
    end
`else
    bypass_s  = 1'b0;
    rd_data_s = data_q[bus_io.io_rreq_bits_id][bus_io.io_rreq_bits_offset];
`endif
    // Reset masks the hit so nothing is accepted while valid bits are still being cleared.
    hit_s       = !reset && bus_io.io_rreq_valid && (beat_valid_s || bypass_s);
    rreq_fire_s = hit_s && (!rresp_valid_q || bus_io.io_rresp_ready);
  end

  // Next-state of the beat-valid bits: clear first, so a same-cycle write survives it.
  always_comb begin
    valid_d = valid_q;
    if (bus_io.io_clear_valid) begin
      valid_d[bus_io.io_clear_id] = {N_BEATS{1'b0}};
    end else begin
      valid_d = valid_d;
    end
    if (bus_io.io_wreq_valid) begin
      valid_d[bus_io.io_wreq_bits_id][bus_io.io_wreq_bits_offset] = 1'b1;
    end else begin
      valid_d = valid_d;
    end
  end

  // Response register next-state: load on accept, drop on handshake, otherwise hold.
  always_comb begin
    rresp_valid_d = rresp_valid_q;
    rresp_data_d  = rresp_data_q;
    if (rreq_fire_s) begin
      rresp_valid_d = 1'b1;
      rresp_data_d  = rd_data_s;
    end else if (bus_io.io_rresp_ready) begin
      rresp_valid_d = 1'b0;
    end else begin
      rresp_valid_d = rresp_valid_q;
    end
  end

  // Per-slot full flags, forced low while reset is asserted.
  always_comb begin
    line_full_s = {N_IDS{1'b0}};
    for (int i = 0; i < N_IDS; i++) begin
      line_full_s[i] = (&valid_q[i]) & ~reset;
    end
  end

  // Control state: valid bits and response register.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q       <= '{default: {N_BEATS{1'b0}}};
      rresp_valid_q <= 1'b0;
      rresp_data_q  <= {DATA_W{1'b0}};
    end else begin
      valid_q       <= valid_d;
      rresp_valid_q <= rresp_valid_d;
      rresp_data_q  <= rresp_data_d;
    end
  end

  // Beat storage; deliberately not reset, only the valid bits qualify its contents.
  always_ff @(posedge clock) begin
    if (bus_io.io_wreq_valid) begin
      data_q[bus_io.io_wreq_bits_id][bus_io.io_wreq_bits_offset] <= bus_io.io_wreq_bits_data;
    end
  end

  assign bus_io.io_wreq_ready      = 1'b1;
  assign bus_io.io_rreq_ready      = rreq_fire_s;
  assign bus_io.io_rresp_valid     = rresp_valid_q;
  assign bus_io.io_rresp_bits_data = rresp_data_q;
  assign bus_io.io_line_full       = line_full_s;
endmodule

// File: tb/tb_boom_line_buffer.sv
// Directed bench for boom_line_buffer: a vector table for the steady-state traffic
// plus hand sequences for the stall, same-cycle write/read and mid-transfer reset cases.
module tb_boom_line_buffer;
  logic clock;
  logic reset;
  int   n_cmp;
  int   n_bad;

  boom_line_buffer_if #(.DATA_W(128), .N_IDS(4)) bus ();

  boom_line_buffer #(.DATA_W(128), .N_IDS(4), .N_BEATS(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wv;
    logic [1:0]  wid;
    logic [1:0]  woff;
    logic [15:0] wd;
    logic        rv;
    logic [1:0]  rid;
    logic [1:0]  roff;
    logic        rrdy;
    logic        clr;
    logic [1:0]  cid;
    logic        e_rr;
    logic        e_rv;
    logic [15:0] e_rd;
    logic [3:0]  e_lf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic wv, input logic [1:0] wid, input logic [1:0] woff,
                              input logic [15:0] wd, input logic rv, input logic [1:0] rid,
                              input logic [1:0] roff, input logic rrdy, input logic clr,
                              input logic [1:0] cid, input logic e_rr, input logic e_rv,
                              input logic [15:0] e_rd, input logic [3:0] e_lf);
    vec_t v;
    v.wv = wv;  v.wid = wid;  v.woff = woff;  v.wd = wd;
    v.rv = rv;  v.rid = rid;  v.roff = roff;  v.rrdy = rrdy;
    v.clr = clr; v.cid = cid;
    v.e_rr = e_rr; v.e_rv = e_rv; v.e_rd = e_rd; v.e_lf = e_lf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [1:0] wid, input logic [1:0] woff,
                       input logic [15:0] wd, input logic rv, input logic [1:0] rid,
                       input logic [1:0] roff, input logic rrdy, input logic clr,
                       input logic [1:0] cid);
    bus.io_wreq_valid       = wv;
    bus.io_wreq_bits_id     = wid;
    bus.io_wreq_bits_offset = woff;
    bus.io_wreq_bits_data   = {112'd0, wd};
    bus.io_rreq_valid       = rv;
    bus.io_rreq_bits_id     = rid;
    bus.io_rreq_bits_offset = roff;
    bus.io_rresp_ready      = rrdy;
    bus.io_clear_valid      = clr;
    bus.io_clear_id         = cid;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    // w: wv wid woff wd | r: rv rid roff rrdy | clr cid | expect rr rv rd lf
    tbl.push_back(mk(1'b1, 2'd2, 2'd0, 16'hA0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0000));
    tbl.push_back(mk(1'b1, 2'd2, 2'd1, 16'hA1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0000));
    tbl.push_back(mk(1'b1, 2'd2, 2'd2, 16'hA2, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0000));
    tbl.push_back(mk(1'b1, 2'd2, 2'd3, 16'hA3, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0000));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0100));
    tbl.push_back(mk(1'b1, 2'd0, 2'd0, 16'hB0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0100));
    tbl.push_back(mk(1'b1, 2'd0, 2'd1, 16'hB1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0100));
    tbl.push_back(mk(1'b1, 2'd0, 2'd2, 16'hB2, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0100));
    tbl.push_back(mk(1'b1, 2'd0, 2'd3, 16'hB3, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0100));
    // back-to-back reads of slot 0
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 16'h00, 4'b0101));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 16'hB0, 4'b0101));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd0, 2'd2, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 16'hB1, 4'b0101));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd0, 2'd3, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 16'hB2, 4'b0101));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 16'hB3, 4'b0101));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0101));
    // response backpressure for 3 cycles
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'h00, 4'b0101));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'hA0, 4'b0101));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'hA0, 4'b0101));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 16'hA0, 4'b0101));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd2, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 16'hA0, 4'b0101));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 16'hA1, 4'b0101));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0101));
    // fill slot 3, then clear it together with a write of offset 1
    tbl.push_back(mk(1'b1, 2'd3, 2'd0, 16'hD0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0101));
    tbl.push_back(mk(1'b1, 2'd3, 2'd1, 16'hD1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0101));
    tbl.push_back(mk(1'b1, 2'd3, 2'd2, 16'hD2, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0101));
    tbl.push_back(mk(1'b1, 2'd3, 2'd3, 16'hD3, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0101));
    tbl.push_back(mk(1'b1, 2'd3, 2'd1, 16'hC1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 16'h00, 4'b1101));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0101));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd3, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 16'h00, 4'b0101));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd3, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 16'hC1, 4'b0101));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0101));
    // clear of slot 2 while its beat is being read
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd2, 2'd3, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 16'h00, 4'b0101));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd2, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 16'hA3, 4'b0001));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0001));
    // rewrite of an already-valid beat
    tbl.push_back(mk(1'b1, 2'd0, 2'd0, 16'hE0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0001));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 16'h00, 4'b0001));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 16'hE0, 4'b0001));
    tbl.push_back(mk(1'b0, 2'd0, 2'd0, 16'h00, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h00, 4'b0001));

    // Reset state, with a read request pending throughout.
    reset = 1'b1;
    drive(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0);
    step();
    step();
    chk("rst_rr", {127'd0, bus.io_rreq_ready}, 128'd0);
    chk("rst_lf", {124'd0, bus.io_line_full}, 128'd0);
    chk("rst_wr", {127'd0, bus.io_wreq_ready}, 128'd1);
    chk("rst_rv", {127'd0, bus.io_rresp_valid}, 128'd0);
    chk("rst_rd", bus.io_rresp_bits_data, 128'd0);
    reset = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 16'h00, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0);
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].wv, tbl[i].wid, tbl[i].woff, tbl[i].wd, tbl[i].rv, tbl[i].rid,
            tbl[i].roff, tbl[i].rrdy, tbl[i].clr, tbl[i].cid);
      #1;
      chk($sformatf("v%0d_rr", i), {127'd0, bus.io_rreq_ready}, {127'd0, tbl[i].e_rr});
      chk($sformatf("v%0d_rv", i), {127'd0, bus.io_rresp_valid}, {127'd0, tbl[i].e_rv});
      chk($sformatf("v%0d_lf", i), {124'd0, bus.io_line_full}, {124'd0, tbl[i].e_lf});
      if (tbl[i].e_rv) begin
        chk($sformatf("v%0d_rd", i), bus.io_rresp_bits_data, {112'd0, tbl[i].e_rd});
      end
      step();
    end

    // Read of unwritten slot 1 offset 3 stalls for 5 cycles.
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd1, 2'd3, 1'b1, 1'b0, 2'd0);
      #1;
      chk($sformatf("stall%0d_rr", c), {127'd0, bus.io_rreq_ready}, 128'd0);
      step();
    end
    drive(1'b1, 2'd1, 2'd3, 16'h55, 1'b1, 2'd1, 2'd3, 1'b1, 1'b0, 2'd0);
    #1;
`ifdef LB_WRITE_BYPASS_EN
    chk("wcyc_rr", {127'd0, bus.io_rreq_ready}, 128'd1);
    step();
    drive(1'b0, 2'd0, 2'd0, 16'h00, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0);
    #1;
`else
    chk("wcyc_rr", {127'd0, bus.io_rreq_ready}, 128'd0);
    step();
    drive(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd1, 2'd3, 1'b1, 1'b0, 2'd0);
    #1;
    chk("post_rr", {127'd0, bus.io_rreq_ready}, 128'd1);
    chk("post_rv", {127'd0, bus.io_rresp_valid}, 128'd0);
    step();
    drive(1'b0, 2'd0, 2'd0, 16'h00, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0);
    #1;
`endif
    chk("x55_rv", {127'd0, bus.io_rresp_valid}, 128'd1);
    chk("x55_rd", bus.io_rresp_bits_data, 128'h55);
    step();

    // Reset arriving while a response is held.
    drive(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0);
    #1;
    chk("pre_rr", {127'd0, bus.io_rreq_ready}, 128'd1);
    step();
    reset = 1'b1;
    #1;
    chk("mid_rv", {127'd0, bus.io_rresp_valid}, 128'd1);
    chk("mid_rd", bus.io_rresp_bits_data, 128'hB1);
    chk("mid_rr", {127'd0, bus.io_rreq_ready}, 128'd0);
    chk("mid_lf", {124'd0, bus.io_line_full}, 128'd0);
    chk("mid_wr", {127'd0, bus.io_wreq_ready}, 128'd1);
    step();
    chk("after_rv", {127'd0, bus.io_rresp_valid}, 128'd0);
    chk("after_rd", bus.io_rresp_bits_data, 128'd0);
    chk("after_lf", {124'd0, bus.io_line_full}, 128'd0);
    reset = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 16'h00, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0);
    #1;
    chk("after_rr01", {127'd0, bus.io_rreq_ready}, 128'd0);
    bus.io_rreq_bits_id = 2'd2;
    bus.io_rreq_bits_offset = 2'd2;
    #1;
    chk("after_rr22", {127'd0, bus.io_rreq_ready}, 128'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
